// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Frame length grows by one parity bit when PISO_PARITY_EN is defined.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer.
// Handshake: a word transfers on the rising edge where in_valid && in_ready; the source holds in_data/in_valid until then.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_data, in_valid, ser_en,
        input  in_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  in_data, in_valid, ser_en,
        output in_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Loadable zero-filling shift register; bit_out is the bit currently presented.
// Zero fill means the register is empty (bit_out=0) once a whole frame has shifted out.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             bit_out
);
    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift_en) begin
            if (MSB_FIRST) sr <= {sr[WIDTH-2:0], 1'b0};
            else           sr <= {1'b0, sr[WIDTH-1:1]};
        end
    end

    assign bit_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and per-bit valid/last output.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    piso_serializer_if.slave   bus,
    output state_t             state_dbg
);
    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W     = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 ser_valid_q;
    logic                 ser_last_q;
    logic                 busy_q;
    logic                 accept;
    logic                 shift_en;
    logic                 ser_bit;
    logic [FRAME_LEN-1:0] load_vec;

    assign bus.in_ready = (state == IDLE) || (state == SHIFT && ser_last_q && bus.ser_en);
    assign accept       = bus.in_valid && bus.in_ready;
    assign shift_en     = (state == SHIFT) && bus.ser_en;

`ifdef PISO_PARITY_EN
    // Parity rides in the extra shift-register slot so it leaves after the data bits.
    logic parity;
    assign parity = ^bus.in_data;
    if (MSB_FIRST) begin : g_load_msb
        assign load_vec = {bus.in_data, parity};
    end else begin : g_load_lsb
        assign load_vec = {parity, bus.in_data};
    end
`else
    assign load_vec = bus.in_data;
`endif

    piso_shift_reg #(
        .WIDTH     (FRAME_LEN),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept),
        .load_data (load_vec),
        .shift_en  (shift_en),
        .bit_out   (ser_bit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SHIFT;
                        cnt         <= '0;
                        ser_valid_q <= 1'b1;
                        ser_last_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.ser_en) begin
                        if (ser_last_q) begin
                            cnt        <= '0;
                            ser_last_q <= 1'b0;
                            if (!accept) begin
                                state       <= IDLE;
                                ser_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                            end
                        end else begin
                            cnt        <= cnt + CNT_W'(1);
                            ser_last_q <= ((cnt + CNT_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ser_out   = ser_bit;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.busy      = busy_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: WIDTH=5 with MSB-first and LSB-first instances.
// Expected bit streams are written out by hand for both PISO_PARITY_EN builds.
module tb_piso_serializer;
  import piso_serializer_pkg::*;

`ifdef PISO_PARITY_EN
  localparam int FL = 6;
  localparam logic [5:0] EXP_A = 6'b101011;  // 10101 + parity 1
  localparam logic [5:0] EXP_B = 6'b010100;  // 01010 + parity 0
  localparam logic [5:0] EXP_S = 6'b110011;  // 11001 + parity 1
  localparam logic [5:0] EXP_P = 6'b101101;  // 10110 + parity 1
  localparam logic [5:0] EXP_L = 6'b110000;  // 00011 LSB-first + parity 0
`else
  localparam int FL = 5;
  localparam logic [5:0] EXP_A = 6'b010101;
  localparam logic [5:0] EXP_B = 6'b001010;
  localparam logic [5:0] EXP_S = 6'b011001;
  localparam logic [5:0] EXP_P = 6'b010110;
  localparam logic [5:0] EXP_L = 6'b011000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(5)) if_msb ();
  piso_serializer_if #(.WIDTH(5)) if_lsb ();
  state_t state_msb;
  state_t state_lsb;

  piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (if_msb),
    .state_dbg (state_msb)
  );

  piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (if_lsb),
    .state_dbg (state_lsb)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present a word for one edge on the MSB-first instance (must be in IDLE)
  task automatic send(input logic [4:0] w);
    if_msb.in_data  = w;
    if_msb.in_valid = 1'b1;
    tick();
    if_msb.in_valid = 1'b0;
  endtask

  // scoreboard for one frame of the MSB-first instance, ser_en held high
  task automatic expect_frame(input string tag, input logic [5:0] exp_bits);
    for (int i = 0; i < FL; i++) begin
      check({tag, "_bit"},   32'(if_msb.ser_out),   32'(exp_bits[FL-1-i]));
      check({tag, "_valid"}, 32'(if_msb.ser_valid), 32'd1);
      check({tag, "_last"},  32'(if_msb.ser_last),  32'(i == FL-1));
      check({tag, "_busy"},  32'(if_msb.busy),      32'd1);
      check({tag, "_rdy"},   32'(if_msb.in_ready),  32'(i == FL-1));
      tick();
    end
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_out"},   32'(if_msb.ser_out),   32'd0);
    check({tag, "_valid"}, 32'(if_msb.ser_valid), 32'd0);
    check({tag, "_last"},  32'(if_msb.ser_last),  32'd0);
    check({tag, "_busy"},  32'(if_msb.busy),      32'd0);
    check({tag, "_rdy"},   32'(if_msb.in_ready),  32'd1);
    check({tag, "_state"}, 32'(state_msb),        32'(IDLE));
  endtask

  initial begin
    int k;
    int stalls;
    reset_n          = 1'b0;
    if_msb.in_data   = '0;
    if_msb.in_valid  = 1'b0;
    if_msb.ser_en    = 1'b1;
    if_lsb.in_data   = '0;
    if_lsb.in_valid  = 1'b0;
    if_lsb.ser_en    = 1'b1;

    // reset state
    repeat (3) tick();
    expect_idle("rst");
    check("rst_lsb_out", 32'(if_lsb.ser_out), 32'd0);
    reset_n = 1'b1;
    tick();
    expect_idle("post_rst");

    // single frame
    send(5'b10101);
    expect_frame("single", EXP_A);
    expect_idle("single_end");

    // back-to-back: B is held while A shifts and is taken on A's last bit
    if_msb.in_data  = 5'b10101;
    if_msb.in_valid = 1'b1;
    tick();
    if_msb.in_data  = 5'b01010;
    expect_frame("b2b_a", EXP_A);
    if_msb.in_valid = 1'b0;
    expect_frame("b2b_b", EXP_B);
    expect_idle("b2b_end");

    // stall three cycles at bit index 2
    send(5'b11001);
    k = 0;
    stalls = 0;
    for (int c = 0; c < FL + 3; c++) begin
      check("stall_bit",   32'(if_msb.ser_out),   32'(EXP_S[FL-1-k]));
      check("stall_valid", 32'(if_msb.ser_valid), 32'd1);
      check("stall_last",  32'(if_msb.ser_last),  32'(k == FL-1));
      if (k == 2 && stalls < 3) begin
        if_msb.ser_en = 1'b0;
        stalls++;
        check("stall_rdy", 32'(if_msb.in_ready), 32'd0);
      end else begin
        if_msb.ser_en = 1'b1;
        k++;
      end
      tick();
    end
    if_msb.ser_en = 1'b1;
    expect_idle("stall_end");

    // reset mid-frame at bit index 3
    send(5'b11111);
    repeat (3) tick();
    check("midrst_pre_out",   32'(if_msb.ser_out),   32'd1);
    check("midrst_pre_valid", 32'(if_msb.ser_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_async_out",   32'(if_msb.ser_out),   32'd0);
    check("midrst_async_valid", 32'(if_msb.ser_valid), 32'd0);
    check("midrst_async_busy",  32'(if_msb.busy),      32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < FL + 2; i++) begin
      tick();
      expect_idle("midrst_after");
    end

    // frame whose parity bit is 1 when parity is built in
    send(5'b10110);
    expect_frame("par", EXP_P);
    expect_idle("par_end");

    // LSB-first instance
    if_lsb.in_data  = 5'b00011;
    if_lsb.in_valid = 1'b1;
    tick();
    if_lsb.in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      check("lsb_bit",   32'(if_lsb.ser_out),   32'(EXP_L[FL-1-i]));
      check("lsb_valid", 32'(if_lsb.ser_valid), 32'd1);
      check("lsb_last",  32'(if_lsb.ser_last),  32'(i == FL-1));
      tick();
    end
    check("lsb_end_out",   32'(if_lsb.ser_out),   32'd0);
    check("lsb_end_busy",  32'(if_lsb.busy),      32'd0);
    check("lsb_end_state", 32'(state_lsb),        32'(IDLE));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that feeds the serial bit-sequence detectors (`d_in`) one bit per enabled clock.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out with a per-bit valid and a last-bit marker.
- Supports back-to-back frames with no idle gap, and a stall input so downstream pacing can be controlled.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_en  input  1  shift enable; 0 stalls the frame.
- ser_out  output  1  serial bit; connects to the detector's d_in.
- ser_valid  output  1  ser_out carries a frame bit.
- ser_last  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (async assert, sync release): state IDLE; ser_out=0, ser_valid=0, ser_last=0, busy=0, bit counter=0, shift register=0.
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress.
- Handshake: accept on the rising edge where in_valid && in_ready. in_data is sampled only at that edge.
- in_ready = (state==IDLE) || (state==SHIFT && ser_last && ser_en). It is combinational from registered state and ser_en.
- IDLE + accept: load the shift register and set counter=0. Go to SHIFT. The first bit is on ser_out in the next cycle (latency 1 clk from accept). ser_valid=1 and busy=1 from that cycle.
- SHIFT, ser_en=1: advance one bit per clock and increment the counter.
- SHIFT, ser_en=0: hold ser_out, counter, ser_valid and ser_last unchanged. No word is accepted.
- ser_last=1 exactly when counter==FRAME_LEN-1. FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature.
- Last bit with ser_en=1 and an accept: load the new word. Its first bit follows with no gap and the counter restarts at 0.
- Last bit with ser_en=1 and no accept: go to IDLE. ser_out returns to 0; ser_valid, ser_last and busy go low.
- IDLE output levels: ser_out is held at 0, so an idle line never contributes 1s to the detector.
- in_valid=1 while in_ready=0: ignored. The upstream side must hold the word until it is accepted.
- Reset mid-frame: the frame is aborted immediately. No partial bits appear after reset release, and there is no replay.
- All outputs except in_ready are registered.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the WIDTH data bits) is appended after the data bits, so FRAME_LEN=WIDTH+1.
  - Parity is computed at the accept edge and stored.
  - ser_last marks the parity bit.
- Undefined:
  - FRAME_LEN=WIDTH.
  - No parity logic or storage is present.

Decomposition:
- Shared package: state enum (IDLE=1'b0, SHIFT=1'b1); counter width localparam CNT_W=$clog2(WIDTH+1); FRAME_LEN derivation.
- Sub-module piso_shift_reg:
  - Load, shift-enable and direction (MSB_FIRST).
  - Outputs the current bit.
- The top level holds the FSM, counter, handshake and the optional parity logic.

Test Plan (WIDTH=5, MSB_FIRST=1 unless noted):
- Reset → all outputs 0, in_ready=1.
- Single frame: accept 5'b10101, ser_en=1 → ser_out 1,0,1,0,1 over the next 5 cycles with ser_valid=1. ser_last=1 on the 5th bit only. Then ser_out=0 and busy=0.
- Back-to-back: 5'b10101 then 5'b01010 presented while the 1st frame's last bit is out → serial stream 1010101010 with no gap. in_ready=1 only in IDLE and on the last-bit cycle.
- Stall: ser_en=0 for 3 cycles at bit index 2 of 5'b11001 → ser_out holds 0 for 3 extra cycles and the counter does not advance. Total frame duration is 8 cycles.
- Reset mid-frame: assert reset_n=0 at bit index 3 → ser_out and ser_valid drop to 0 asynchronously. After release the block is in IDLE with no further bits.
- MSB_FIRST=0, 5'b00011 → ser_out 1,1,0,0,0.
- PISO_PARITY_EN with 5'b10110 → data bits 1,0,1,1,0 followed by parity bit 1. ser_last is on the 6th bit.
